// File: rtl/itrx_amba3_ahblite_mux_dec.sv
// AHB-Lite single-master fabric core: address decoder, registered data-phase
// select, slave response multiplexor and a built-in default slave that
// answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR and counts them.
module itrx_amba3_ahblite_mux_dec #(
    parameter int          HDATAW    = 64,
    parameter int          NS        = 16,
    parameter int          REGION_W  = 24,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNTW      = 16
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [31:0]          haddr,
    input  logic [1:0]           htrans,
    output logic [NS-1:0]        hsel,
    output logic                 hready,
    output logic                 hresp,
    output logic [HDATAW-1:0]    hrdata,
    input  logic [NS-1:0]        hreadyout_s,
    input  logic [NS-1:0]        hresp_s,
    input  logic [NS*HDATAW-1:0] hrdata_s,
    output logic [CNTW-1:0]      err_cnt,
    input  logic                 err_clr
);

    localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    logic [31:0]     offset;
    logic [31:0]     region;
    logic            mapped;
    logic [IDXW-1:0] idx;
    logic            addr_err;

    logic            dsel_def;
    logic [IDXW-1:0] dsel_idx;

    ds_state_t       state_q;
    ds_state_t       state_d;
    logic            def_ready;
    logic            def_resp;
    logic            err_inc;

    // Address decode; the haddr >= BASE_ADDR guard keeps wrapped offsets unmapped
    always_comb begin
        offset   = haddr - BASE_ADDR;
        region   = offset >> REGION_W;
        mapped   = (haddr >= BASE_ADDR) && (region < 32'(NS));
        idx      = region[IDXW-1:0];
        addr_err = !mapped && (htrans inside {2'b10, 2'b11});
    end

    // One-hot slave select, purely from haddr
    always_comb begin
        hsel = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            if (mapped && (idx == IDXW'(i))) begin
                hsel[i] = 1'b1;
            end
        end
    end

    // Data-phase owner, advanced only when the current data phase completes
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dsel_def <= 1'b1;
            dsel_idx <= '0;
        end else if (hready) begin
            dsel_def <= !mapped;
            dsel_idx <= mapped ? idx : '0;
        end
    end

    // Default-slave state register
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Default-slave next state; ERR2 may chain straight into a new ERR1
    always_comb begin
        state_d = DS_IDLE;
        case (state_q)
            DS_IDLE: state_d = (hready && addr_err) ? DS_ERR1 : DS_IDLE;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = addr_err ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    // Default-slave response outputs
    always_comb begin
        def_ready = 1'b1;
        def_resp  = 1'b0;
        case (state_q)
            DS_ERR1: begin
                def_ready = 1'b0;
                def_resp  = 1'b1;
            end
            DS_ERR2: begin
                def_ready = 1'b1;
                def_resp  = 1'b1;
            end
            default: begin
                def_ready = 1'b1;
                def_resp  = 1'b0;
            end
        endcase
    end

    assign err_inc = (state_d == DS_ERR1) && (state_q != DS_ERR1);

    // Saturating error counter; a clear coincident with a new error leaves 1
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= err_inc ? CNTW'(1) : '0;
        end else if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    // Response mux driven by the registered data-phase owner
    always_comb begin
        hready = def_ready;
        hresp  = def_resp;
        hrdata = '0;
        if (!dsel_def) begin
            for (int unsigned i = 0; i < NS; i++) begin
                if (dsel_idx == IDXW'(i)) begin
                    hready = hreadyout_s[i];
                    hresp  = hresp_s[i];
                    hrdata = hrdata_s[i*HDATAW +: HDATAW];
                end
            end
        end
    end

endmodule

// File: doc/itrx_amba3_ahblite_mux_dec.md
Name: itrx_amba3_ahblite_mux_dec

Overview:
- Parametrised AHB-Lite bus-fabric core for one master and NS slaves: address-phase decoder, registered data-phase select, and slave-to-master response multiplexor.
- Includes a built-in default slave. It answers any address outside the mapped window with a standards-compliant two-cycle ERROR response, and it counts those errors.
- Sits between a master and the slave set, replacing separate decoder and mux logic.

Parameters:
- HDATAW, 64, data bus width in bits.
- NS, 16, number of mapped slaves (1..64).
- REGION_W, 24, log2 of the byte size of each slave region.
- BASE_ADDR, 32'h0000_0000, start of slave 0's region; must be aligned to 2^REGION_W.
- CNTW, 16, width of the error counter.

Ports:
- hclk  input  1  bus clock; all state on the rising edge.
- hreset  input  1  asynchronous, active-high reset.
- haddr  input  32  master address.
- htrans  input  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hsel  output  NS  one-hot slave select (combinational from haddr).
- hready  output  1  to master and to all slaves' hready inputs.
- hresp  output  1  to master (0=OKAY, 1=ERROR).
- hrdata  output  HDATAW  to master.
- hreadyout_s  input  NS  per-slave hreadyout.
- hresp_s  input  NS  per-slave hresp.
- hrdata_s  input  NS*HDATAW  per-slave read data; slave i occupies bits [i*HDATAW +: HDATAW].
- err_cnt  output  CNTW  count of default-slave ERROR responses, saturating.
- err_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Decode (address phase):
  - idx = (haddr - BASE_ADDR) >> REGION_W.
  - Address is mapped iff haddr >= BASE_ADDR and idx < NS.
  - hsel[idx] = 1 when mapped; hsel is all-zero when unmapped.
  - hsel is independent of htrans and hready, per AHB-Lite.
- Data-phase select register: on each hclk edge with hready = 1, capture dsel. dsel = idx when mapped, else DEFAULT. Hold dsel while hready = 0.
- Response mux, when dsel = slave i:
  - hready = hreadyout_s[i]
  - hresp = hresp_s[i]
  - hrdata = hrdata_s[i]
- Response mux, when dsel = DEFAULT: hready and hresp come from the default-slave FSM; hrdata = 0.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE outputs: hready = 1, hresp = 0.
  - ERR1 outputs: hready = 0, hresp = 1.
  - ERR2 outputs: hready = 1, hresp = 1.
  - IDLE -> ERR1 when hready = 1 and the address is unmapped and htrans[1] = 1 (NONSEQ/SEQ).
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 if a new unmapped NONSEQ/SEQ is presented in the same cycle; else ERR2 -> IDLE.
  - IDLE/BUSY transfers to unmapped addresses get a zero-wait OKAY and leave the FSM in IDLE.
- Back-to-back: pipelining is seamless between any slave and DEFAULT. One cycle's data-phase owner can differ from the next; no idle cycles are inserted.
- err_cnt:
  - +1 on every IDLE->ERR1 or ERR2->ERR1 transition.
  - Saturates at 2^CNTW-1; does not wrap.
  - err_clr alone sets the count to 0.
  - err_clr coincident with an increment yields 1.
- Reset (asynchronous, any time including mid-wait-state):
  - dsel = DEFAULT, FSM = IDLE, err_cnt = 0.
  - Resulting outputs: hready = 1, hresp = 0, hrdata = 0.
  - hsel follows haddr combinationally even during reset.
- Latency: decode is 0 cycles (combinational). The data-phase response mux reflects the select registered one cycle earlier.
- Address wrap: when BASE_ADDR + NS*2^REGION_W exceeds 2^32, only addresses that reach idx < NS without 32-bit overflow are mapped.

Test Plan:
- Reset, then NONSEQ read to BASE_ADDR+0x10 (slave 0 hrdata_s = 0xA5A5). Expect hsel = 1 during the address phase. Next cycle: hrdata = 0xA5A5, hready = 1, hresp = 0.
- NS = 16, REGION_W = 24, BASE = 0. Write to 0x0300_0004 while slave 3 holds hreadyout_s[3] = 0 for 2 cycles. Expect hsel[3] = 1 and hready low for exactly 2 data-phase cycles; the next transfer's address is held.
- NONSEQ to unmapped 0x1000_0000. Expect hsel = 0, then hready/hresp = 0/1 followed by 1/1, and err_cnt = 1.
- Back-to-back unmapped NONSEQ, unmapped SEQ, then slave 2 NONSEQ. Expect the sequence ERR1, ERR2, ERR1, ERR2, then slave 2's response with no gap, and err_cnt = 2.
- IDLE to an unmapped address. Expect hready = 1, hresp = 0, and err_cnt unchanged.
- With CNTW = 2:
  - 5 unmapped errors: err_cnt saturates at 3.
  - err_clr coincident with an ERR1 entry: err_cnt = 1.
  - Assert hreset during ERR1: hready = 1, hresp = 0, err_cnt = 0 immediately.
